// File: rtl/risc_alu_pkg.sv
// Shared definitions for the risc_alu block: operand width and the
// operation-class, logic-function and shift-function encodings.
package risc_alu_pkg;

   localparam int DATA_W = 32;
   localparam int SHAMT_W = 5;
   localparam int POP_W = 6;

   typedef enum logic [2:0] {
      FN_LUI    = 3'b000,
      FN_SLT    = 3'b001,
      FN_SGT    = 3'b010,
      FN_ADDSUB = 3'b011,
      FN_LOGIC  = 3'b100,
      FN_SHIFT  = 3'b101,
      FN_HAM    = 3'b110,
      FN_ZERO   = 3'b111
   } fn_class_e;

   typedef enum logic [1:0] {
      LOGIC_AND = 2'b00,
      LOGIC_OR  = 2'b01,
      LOGIC_XOR = 2'b10,
      LOGIC_NOR = 2'b11
   } logic_fn_e;

   typedef enum logic [1:0] {
      SHIFT_SLL  = 2'b00,
      SHIFT_SRL  = 2'b01,
      SHIFT_SRA  = 2'b10,
      SHIFT_RSVD = 2'b11
   } shift_fn_e;

endpackage

// File: rtl/risc_alu_popcount.sv
// Population count of a 32-bit word; result range 0..32 fits in 6 bits.
module risc_alu_popcount
   import risc_alu_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   output logic [POP_W-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < DATA_W; i++) begin
         count = count + POP_W'(word[i]);
      end
   end

endmodule

// File: rtl/risc_alu.sv
// Single-cycle ALU: one combinational compute block feeding one output
// register stage. Results and overflow update only on in_valid.
module risc_alu
   import risc_alu_pkg::*;
#(
   parameter int DATA_W = risc_alu_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              add_sub,
   input  logic              ConstVar,
   input  logic [1:0]        LogicFn,
   input  logic [1:0]        ShiftFn,
   input  logic [2:0]        FnClass,
   output logic [DATA_W-1:0] ALU_result,
   output logic              Overflow,
   output logic              out_valid
);

   logic [DATA_W-1:0]  sum;
   logic [DATA_W-1:0]  diff;
   logic [SHAMT_W-1:0] shamt;
   logic [POP_W-1:0]   pop_count;
   logic [DATA_W-1:0]  result_next;
   logic               overflow_next;

   risc_alu_popcount u_popcount (
      .word  (x),
      .count (pop_count)
   );

   assign sum   = x + y;
   assign diff  = x - y;
   assign shamt = ConstVar ? SHAMT_W'(1) : y[SHAMT_W-1:0];

   always_comb begin
      result_next   = '0;
      overflow_next = 1'b0;
      case (FnClass)
         FN_LUI: result_next = {y[15:0], 16'h0000};
         FN_SLT: result_next = DATA_W'($signed(x) < $signed(y));
         FN_SGT: result_next = DATA_W'($signed(x) > $signed(y));
         FN_ADDSUB: begin
            // Signed overflow: sign of result disagrees with what the operand signs force.
            if (add_sub) begin
               result_next   = diff;
               overflow_next = (x[DATA_W-1] != y[DATA_W-1]) && (diff[DATA_W-1] != x[DATA_W-1]);
            end else begin
               result_next   = sum;
               overflow_next = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
            end
         end
         FN_LOGIC: begin
            case (LogicFn)
               LOGIC_AND: result_next = x & y;
               LOGIC_OR:  result_next = x | y;
               LOGIC_XOR: result_next = x ^ y;
               default:   result_next = ~(x | y);
            endcase
         end
         FN_SHIFT: begin
            case (ShiftFn)
               SHIFT_SLL: result_next = x << shamt;
               SHIFT_SRL: result_next = x >> shamt;
               SHIFT_SRA: result_next = $unsigned($signed(x) >>> shamt);
               default:   result_next = '0;
            endcase
         end
         FN_HAM:  result_next = {{(DATA_W-POP_W){1'b0}}, pop_count};
         default: result_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ALU_result <= '0;
         Overflow   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            ALU_result <= result_next;
            Overflow   <= overflow_next;
         end
      end
   end

endmodule

// File: tb/tb_risc_alu.sv
// Scoreboard bench for risc_alu: directed vectors plus random traffic,
// checked against a plain-arithmetic reference model.
module tb_risc_alu;
   import risc_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] x, y;
   logic        add_sub, ConstVar;
   logic [1:0]  LogicFn, ShiftFn;
   logic [2:0]  FnClass;
   logic [31:0] ALU_result;
   logic        Overflow, out_valid;

   typedef struct packed {
      logic [31:0] res;
      logic        ov;
   } exp_t;

   exp_t        scb[$];
   int          checks = 0;
   int          passed = 0;
   logic [31:0] last_res = '0;
   logic        last_ov = 1'b0;

   risc_alu #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .x          (x),
      .y          (y),
      .add_sub    (add_sub),
      .ConstVar   (ConstVar),
      .LogicFn    (LogicFn),
      .ShiftFn    (ShiftFn),
      .FnClass    (FnClass),
      .ALU_result (ALU_result),
      .Overflow   (Overflow),
      .out_valid  (out_valid)
   );

   always #5 clk = ~clk;

   function automatic exp_t ref_model(logic [31:0] a, logic [31:0] b, logic as_, logic cv,
                                      logic [1:0] lf, logic [1:0] sf, logic [2:0] fc);
      exp_t   e;
      longint sa, sb, r;
      int     sxa;
      int     s;
      logic [4:0] b_lo;
      e    = '0;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      b_lo = b[4:0];
      s    = cv ? 1 : int'(b_lo);
      case (fc)
         3'd0: e.res = b << 16;
         3'd1: e.res = (sa < sb) ? 32'd1 : 32'd0;
         3'd2: e.res = (sa > sb) ? 32'd1 : 32'd0;
         3'd3: begin
            r     = as_ ? (sa - sb) : (sa + sb);
            e.res = r[31:0];
            e.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
         end
         3'd4: begin
            case (lf)
               2'd0: e.res = a & b;
               2'd1: e.res = a | b;
               2'd2: e.res = a ^ b;
               default: e.res = ~(a | b);
            endcase
         end
         3'd5: begin
            sxa = $signed(a);
            case (sf)
               2'd0: e.res = a << s;
               2'd1: e.res = a >> s;
               2'd2: e.res = sxa >>> s;
               default: e.res = 32'd0;
            endcase
         end
         3'd6: e.res = $countones(a);
         default: e.res = 32'd0;
      endcase
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
   endtask

   task automatic drive(bit v, logic [31:0] a, logic [31:0] b, bit as_, bit cv,
                        logic [1:0] lf, logic [1:0] sf, logic [2:0] fc);
      @(negedge clk);
      in_valid = v;
      x = a; y = b; add_sub = as_; ConstVar = cv;
      LogicFn = lf; ShiftFn = sf; FnClass = fc;
      if (v) scb.push_back(ref_model(a, b, as_, cv, lf, sf, fc));
   endtask

   task automatic check_reset_outputs(string tag);
      check({tag, "_result"}, ALU_result, 32'd0);
      check({tag, "_ov"}, {31'd0, Overflow}, 32'd0);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a result.
   initial begin
      exp_t e;
      logic exp_v;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            exp_v = in_valid;
            #1;
            if (rst_n) begin
               check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
               if (out_valid) begin
                  if (scb.size() == 0) begin
                     checks++;
                     $display("FAIL scoreboard_empty: got result %h, required no result", ALU_result);
                  end else begin
                     e = scb.pop_front();
                     check("result", ALU_result, e.res);
                     check("overflow", {31'd0, Overflow}, {31'd0, e.ov});
                     last_res = e.res;
                     last_ov  = e.ov;
                  end
               end else begin
                  check("hold_result", ALU_result, last_res);
                  check("hold_ov", {31'd0, Overflow}, {31'd0, last_ov});
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0;
      x = '0; y = '0; add_sub = 0; ConstVar = 0; LogicFn = 0; ShiftFn = 0; FnClass = 0;
      #2;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD/SUB
      drive(1, 32'd10, 32'd5, 0, 0, 0, 0, 3'd3);
      drive(1, 32'd10, 32'd5, 1, 0, 0, 0, 3'd3);
      drive(1, 32'd9,  32'd1, 0, 0, 0, 0, 3'd3);
      drive(1, 32'd9,  32'd1, 1, 0, 0, 0, 3'd3);
      // Logic
      for (int f = 0; f < 4; f++) drive(1, 32'd10, 32'd5, 0, 0, 2'(f), 0, 3'd4);
      // Compare and LUI
      drive(1, 32'd5,  32'd10, 0, 0, 0, 0, 3'd1);
      drive(1, 32'd10, 32'd5,  0, 0, 0, 0, 3'd2);
      drive(1, 32'd10, 32'd10, 0, 0, 0, 0, 3'd2);
      drive(1, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 0, 3'd1);
      drive(1, 32'd0, 32'h0000_ABCD, 0, 0, 0, 0, 3'd0);
      // Overflow corners
      drive(1, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 3'd3);
      drive(1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0, 3'd3);
      drive(1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 3'd3);
      drive(1, 32'h8000_0000, 32'd1, 1, 0, 0, 0, 3'd3);
      // Shifts
      drive(1, 32'd1,         32'd3, 0, 0, 0, 2'd0, 3'd5);
      drive(1, 32'hF000_0000, 32'd4, 0, 0, 0, 2'd1, 3'd5);
      drive(1, 32'hF000_0000, 32'd4, 0, 0, 0, 2'd2, 3'd5);
      drive(1, 32'd1,         32'd9, 0, 1, 0, 2'd0, 3'd5);
      drive(1, 32'h8000_0000, 32'd9, 0, 1, 0, 2'd1, 3'd5);
      drive(1, 32'h8000_0000, 32'd9, 0, 1, 0, 2'd2, 3'd5);
      drive(1, 32'h8000_0000, 32'd31, 0, 0, 0, 2'd2, 3'd5);
      drive(1, 32'h1234_5678, 32'd3, 0, 0, 0, 2'd3, 3'd5);
      // HAM and class 111
      drive(1, 32'hF0F0_000F, 32'd0, 0, 0, 0, 0, 3'd6);
      drive(1, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0, 3'd6);
      drive(1, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0, 3'd7);
      // Idle with junk inputs: outputs must hold
      drive(0, 32'hDEAD_BEEF, 32'h1, 0, 0, 0, 0, 3'd3);
      drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 3'd0);

      // Reset mid-stream with a result in flight
      drive(1, 32'd100, 32'd23, 0, 0, 0, 0, 3'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midreset");
      scb.delete();
      last_res = '0;
      last_ov  = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("midreset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h7FFF_FFFF;
            1: ra = 32'h8000_0000;
            2: rb = ra;
            default: ;
         endcase
         drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
               2'($urandom), 2'($urandom), 3'($urandom));
      end

      drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 3'd0);
      drive(0, 32'h0, 32'h0, 0, 0, 0, 0, 3'd0);
      @(posedge clk);
      #2;
      check("drain", 32'(scb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/risc_alu.md
RISC_ALU -- requirements
Module: risc_alu

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; only 32 is required to be supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operands/controls valid this cycle.
REQ-005 x  input  32  operand A.
REQ-006 y  input  32  operand B / immediate / shift amount.
REQ-007 add_sub  input  1  0 = add, 1 = subtract (FnClass 011).
REQ-008 ConstVar  input  1  shift amount select: 0 = y[4:0], 1 = constant 1.
REQ-009 LogicFn  input  2  00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 ShiftFn  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
REQ-011 FnClass  input  3  operation class select.
REQ-012 ALU_result  output  32  registered result.
REQ-013 Overflow  output  1  registered signed-overflow flag.
REQ-014 out_valid  output  1  ALU_result/Overflow hold a new result.

Function
REQ-015 Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-016 out_valid is in_valid delayed one cycle; there is no backpressure.
REQ-017 ALU_result and Overflow update only when in_valid=1 and hold otherwise.
REQ-018 FnClass 000 (LUI): result = {y[15:0], 16'h0000}.
REQ-019 FnClass 001 (SLT): result = 1 if signed(x) < signed(y), else 0; add_sub is ignored.
REQ-020 FnClass 010 (SGT): result = 1 if signed(x) > signed(y), else 0; equal operands give 0.
REQ-021 FnClass 011: result = x + y when add_sub=0, x - y when add_sub=1; modulo 2^32 (wrap-around).
REQ-022 Overflow = 1 only for FnClass 011 when the two's-complement signed result overflows:
- add: both operands have the same sign and the result sign differs;
- sub: the operands differ in sign and the result sign differs from x.
REQ-023 Overflow = 0 for every other FnClass.
REQ-024 FnClass 100: bitwise x AND/OR/XOR/NOR y per LogicFn.
REQ-025 FnClass 101: x shifted by amount s, where s = y[4:0] (ConstVar=0) or s = 1 (ConstVar=1).
- SLL and SRL fill with zeros.
- SRA fills with x[31].
- ShiftFn 11 gives result 0.
REQ-026 FnClass 110 (HAM): result = population count of x, zero-extended; range 0..32.
REQ-027 FnClass 111: result = 0 and Overflow = 0.
REQ-028 Control inputs contain no X or Z decoding; every encoding is defined above.

Reset
REQ-029 While rst_n=0, ALU_result=0, Overflow=0 and out_valid=0, applied immediately and independent of clk.
REQ-030 A result in flight when reset asserts is discarded.
REQ-031 The first valid result after rst_n deasserts appears one cycle after the first in_valid edge.

Structure
REQ-032 A shared package holds:
- FnClass codes: LUI, SLT, SGT, ADDSUB, LOGIC, SHIFT, HAM;
- LogicFn and ShiftFn enums;
- DATA_W.
REQ-033 Computation is one combinational always block feeding a single output register stage.
REQ-034 One sub-module, risc_alu_popcount, implements HAM as a 32-bit population count.

Verification
REQ-035 ADD/SUB: x=10, y=5 gives 15 (add_sub=0) and 5 (add_sub=1); x=9, y=1 gives 10 and 8; Overflow=0 throughout.
REQ-036 Logic: x=10, y=5 gives AND 0, OR 0xF, XOR 0xF, NOR 0xFFFFFFF0.
REQ-037 Compare: SLT x=5, y=10 gives 1; SGT x=10, y=5 gives 1; SGT x=y=10 gives 0; LUI y=0x0000ABCD gives 0xABCD0000.
REQ-038 Overflow: add 0x7FFFFFFF+1 gives 0x80000000 with OV=1; sub 0x7FFFFFFF-(-1) gives 0x80000000 with OV=1.
REQ-039 Shifts:
- ConstVar=0: SLL 1 by 3 gives 8; SRL 0xF0000000 by 4 gives 0x0F000000; SRA gives 0xFF000000.
- ConstVar=1: SLL 1 gives 2; SRL 0x80000000 gives 0x40000000; SRA gives 0xC0000000.
REQ-040 HAM and reset:
- HAM x=0xF0F0000F gives 0x0000000C.
- Asserting rst_n low mid-stream clears all outputs to 0 immediately.
- out_valid tracks in_valid with 1-cycle lag.
